// File: rtl/nth_band_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nth_band_predictor_pkg
// Purpose  : Shared widths and saturation bounds for the n-th band predictor
//            (default 16-bit samples, 10-bit Q1.9 alpha).
// Revision : 1.0 - initial release
// ============================================================================
package nth_band_predictor_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ALPHA_WIDTH = 10;

  // Difference of two unsigned samples needs one extra sign bit.
  localparam int DIFF_WIDTH = DEF_DATA_WIDTH + 1;
  // Signed difference times unsigned alpha (alpha carries its own zero sign bit).
  localparam int PROD_WIDTH = DEF_DATA_WIDTH + DEF_ALPHA_WIDTH + 1;
  // Alpha is fixed point with one integer bit.
  localparam int ALPHA_FRAC = DEF_ALPHA_WIDTH - 1;

  // Prediction is clamped to the signed DIFF_WIDTH range.
  localparam logic signed [DIFF_WIDTH-1:0] SAT_MAX = {1'b0, {DEF_DATA_WIDTH{1'b1}}};
  localparam logic signed [DIFF_WIDTH-1:0] SAT_MIN = {1'b1, {DEF_DATA_WIDTH{1'b0}}};

endpackage : nth_band_predictor_pkg
`default_nettype wire

// File: rtl/nth_band_predictor_axis_join4.sv
`default_nettype none
// ============================================================================
// Module   : axis_join4
// Purpose  : Joins the xhat sample stream with the three per-block parameter
//            streams. xhat is popped on every fire; the parameter streams are
//            only peeked and get popped together with the last sample of a block.
// Revision : 1.0 - initial release
// ============================================================================
module axis_join4
  import nth_band_predictor_pkg::*;
(
  input  logic xhat_valid,
  input  logic xhat_last_s,
  input  logic alpha_valid,
  input  logic xmean_valid,
  input  logic xhatmean_valid,
  input  logic out_ready,
  output logic xhat_ready,
  output logic alpha_ready,
  output logic xmean_ready,
  output logic xhatmean_ready,
  output logic fire
);

  // Every ready depends on all four valids, so no stream is consumed alone.
  assign fire           = xhat_valid & alpha_valid & xmean_valid & xhatmean_valid & out_ready;
  assign xhat_ready     = fire;
  assign alpha_ready    = fire & xhat_last_s;
  assign xmean_ready    = fire & xhat_last_s;
  assign xhatmean_ready = fire & xhat_last_s;

endmodule : axis_join4
`default_nettype wire

// File: rtl/nth_band_predictor.sv
`default_nettype none
// ============================================================================
// Module   : nth_band_predictor
// Purpose  : xtilde = xmean + alpha*(xhat - xhatmean) for bands >= 1, as a
//            3-stage valid/ready pipeline (diff, scale, offset+saturate).
//            Optional macro NTHBAND_PREDICTOR_ROUNDING_EN selects round-half-up
//            for the alpha scaling instead of floor.
// Revision : 1.0 - initial release
// ============================================================================
module nth_band_predictor
  import nth_band_predictor_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ALPHA_WIDTH = DEF_ALPHA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  xhat_valid,
  output logic                  xhat_ready,
  input  logic [DATA_WIDTH-1:0] xhat_data,
  input  logic                  xhat_last_s,
  input  logic                  xmean_valid,
  output logic                  xmean_ready,
  input  logic [DATA_WIDTH-1:0] xmean_data,
  input  logic                  xhatmean_valid,
  output logic                  xhatmean_ready,
  input  logic [DATA_WIDTH-1:0] xhatmean_data,
  input  logic                  alpha_valid,
  output logic                  alpha_ready,
  input  logic [ALPHA_WIDTH-1:0] alpha_data,
  output logic                  xtilde_valid,
  input  logic                  xtilde_ready,
  output logic [DATA_WIDTH:0]   xtilde_data
);

  localparam int DW   = DATA_WIDTH + 1;
  localparam int FRAC = ALPHA_WIDTH - 1;
  // One bit beyond the product width so rounding and the mean offset never wrap.
  localparam int SW   = DATA_WIDTH + ALPHA_WIDTH + 2;

  localparam logic signed [SW-1:0] SAT_HI = {{(SW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {{(SW-DATA_WIDTH){1'b1}}, {DATA_WIDTH{1'b0}}};

  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;
  logic fire;

  logic signed [DW-1:0]    s1_diff;
  logic [ALPHA_WIDTH-1:0]  s1_alpha;
  logic [DATA_WIDTH-1:0]   s1_xmean;
  logic signed [SW-1:0]    s2_q;
  logic [DATA_WIDTH-1:0]   s2_xmean;
  logic signed [DW-1:0]    s3_data;

  logic signed [DW-1:0]    diff_next;
  logic signed [SW-1:0]    prod;
  logic signed [SW-1:0]    prod_adj;
  logic signed [SW-1:0]    q_next;
  logic signed [SW-1:0]    sum;
  logic signed [DW-1:0]    sat_next;

  // A stage may load when it is empty or its content leaves this cycle.
  assign s3_ready = !s3_valid | xtilde_ready;
  assign s2_ready = !s2_valid | s3_ready;
  assign s1_ready = !s1_valid | s2_ready;

  axis_join4 u_join (
    .xhat_valid     (xhat_valid),
    .xhat_last_s    (xhat_last_s),
    .alpha_valid    (alpha_valid),
    .xmean_valid    (xmean_valid),
    .xhatmean_valid (xhatmean_valid),
    .out_ready      (s1_ready & ~rst),
    .xhat_ready     (xhat_ready),
    .alpha_ready    (alpha_ready),
    .xmean_ready    (xmean_ready),
    .xhatmean_ready (xhatmean_ready),
    .fire           (fire)
  );

  // Stage arithmetic: difference, scaled product with optional rounding, offset with clamp.
  always_comb begin
    diff_next = $signed({1'b0, xhat_data}) - $signed({1'b0, xhatmean_data});
    prod      = SW'(s1_diff) * SW'($signed({1'b0, s1_alpha}));
`ifdef NTHBAND_PREDICTOR_ROUNDING_EN
    prod_adj  = prod + (SW'(1) <<< (FRAC - 1));
`else
    prod_adj  = prod;
`endif
    q_next    = prod_adj >>> FRAC;
    sum       = s2_q + SW'($signed({1'b0, s2_xmean}));
    if (sum > SAT_HI) begin
      sat_next = SAT_HI[DW-1:0];
    end else if (sum < SAT_LO) begin
      sat_next = SAT_LO[DW-1:0];
    end else begin
      sat_next = sum[DW-1:0];
    end
  end

  // Valid bits of the three stages; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= fire;
      if (s2_ready) s2_valid <= s1_valid;
      if (s3_ready) s3_valid <= s2_valid;
    end
  end

  // Data registers follow their valid bits and hold while the stage is stalled.
  always_ff @(posedge clk) begin
    if (s1_ready && fire) begin
      s1_diff  <= diff_next;
      s1_alpha <= alpha_data;
      s1_xmean <= xmean_data;
    end
    if (s2_ready && s1_valid) begin
      s2_q     <= q_next;
      s2_xmean <= s1_xmean;
    end
    if (s3_ready && s2_valid) begin
      s3_data  <= sat_next;
    end
  end

  assign xtilde_valid = s3_valid;
  assign xtilde_data  = s3_data;

endmodule : nth_band_predictor
`default_nettype wire

// File: tb/tb_nth_band_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_nth_band_predictor
// Purpose  : Scoreboard bench for nth_band_predictor: directed vectors, block
//            framing, randomized stream with gaps/backpressure, mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nth_band_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        xhat_valid, xhat_ready, xhat_last_s;
  logic [15:0] xhat_data;
  logic        xmean_valid, xmean_ready;
  logic [15:0] xmean_data;
  logic        xhatmean_valid, xhatmean_ready;
  logic [15:0] xhatmean_data;
  logic        alpha_valid, alpha_ready;
  logic [9:0]  alpha_data;
  logic        xtilde_valid, xtilde_ready;
  logic [16:0] xtilde_data;

  nth_band_predictor dut (
    .clk(clk), .rst(rst),
    .xhat_valid(xhat_valid), .xhat_ready(xhat_ready), .xhat_data(xhat_data), .xhat_last_s(xhat_last_s),
    .xmean_valid(xmean_valid), .xmean_ready(xmean_ready), .xmean_data(xmean_data),
    .xhatmean_valid(xhatmean_valid), .xhatmean_ready(xhatmean_ready), .xhatmean_data(xhatmean_data),
    .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha_data(alpha_data),
    .xtilde_valid(xtilde_valid), .xtilde_ready(xtilde_ready), .xtilde_data(xtilde_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic last; logic [16:0] exp; } beat_t;
  typedef struct { logic [9:0] a; logic [15:0] m; logic [15:0] hm; } par_t;

  beat_t       xq[$];
  par_t        pq[$];
  logic [16:0] sb[$];
  int          fq[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int pops   = 0;
  int blocks = 0;
  int gap_pct = 0;
  int bp_pct  = 0;
  bit mon_en  = 0;
  bit lat_chk = 0;
  int cur_a, cur_m, cur_hm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: real-valued formula with floor (or round-half-up) and clamp.
  function automatic logic [16:0] model(input int xh, input int xhm, input int xm, input int a);
    longint p, q, s;
    p = longint'(xh - xhm) * a;
`ifdef NTHBAND_PREDICTOR_ROUNDING_EN
    p = p + 256;
`endif
    if (p >= 0) q = p / 512;
    else        q = -((-p + 511) / 512);
    s = q + xm;
    if (s > 65535)  s = 65535;
    if (s < -65536) s = -65536;
    model = s[16:0];
  endfunction

  task automatic add_par(input int a, input int m, input int hm);
    par_t p;
    p.a = a[9:0]; p.m = m[15:0]; p.hm = hm[15:0];
    pq.push_back(p);
    cur_a = a; cur_m = m; cur_hm = hm;
    blocks++;
  endtask

  task automatic add_sample(input int x, input bit last);
    beat_t b;
    b.d = x[15:0]; b.last = last;
    b.exp = model(x, cur_hm, cur_m, cur_a);
    xq.push_back(b);
  endtask

  task automatic add_rand_blocks(input int nsamp);
    int left = nsamp;
    while (left > 0) begin
      int n = $urandom_range(8, 1);
      if (n > left) n = left;
      add_par($urandom_range(1023), $urandom_range(65535), $urandom_range(65535));
      for (int i = 0; i < n; i++) add_sample($urandom_range(65535), i == n - 1);
      left -= n;
    end
  endtask

  task automatic drive(input int max_cyc, input bit until_done);
    int  n = 0;
    bit  done = 0;
    bit  fx, fa, fm, fh;
    while (!done) begin
      @(negedge clk);
      fx = xhat_valid & xhat_ready;
      fa = alpha_valid & alpha_ready;
      fm = xmean_valid & xmean_ready;
      fh = xhatmean_valid & xhatmean_ready;
      if (xhat_ready | alpha_ready | xmean_ready | xhatmean_ready)
        chk("join_readies",
            {24'd0, xhat_valid, alpha_valid, xmean_valid, xhatmean_valid,
             xhat_ready, alpha_ready, xmean_ready, xhatmean_ready},
            {24'd0, 4'hF, 1'b1, {3{xhat_last_s}}});
      if (fx) begin
        sb.push_back(xq[0].exp);
        fq.push_back(cyc);
        void'(xq.pop_front());
      end
      if (fa) begin
        pops++;
        void'(pq.pop_front());
      end
      @(posedge clk);
      #1;
      if (!xhat_valid || fx) xhat_valid = (xq.size() > 0) && ($urandom_range(99) >= gap_pct);
      if (!alpha_valid || fa) alpha_valid = (pq.size() > 0) && ($urandom_range(99) >= gap_pct);
      if (!xmean_valid || fm) xmean_valid = (pq.size() > 0) && ($urandom_range(99) >= gap_pct);
      if (!xhatmean_valid || fh) xhatmean_valid = (pq.size() > 0) && ($urandom_range(99) >= gap_pct);
      if (xq.size() > 0) begin xhat_data = xq[0].d; xhat_last_s = xq[0].last; end
      else               begin xhat_valid = 1'b0; xhat_last_s = 1'b0; end
      if (pq.size() > 0) begin alpha_data = pq[0].a; xmean_data = pq[0].m; xhatmean_data = pq[0].hm; end
      else begin alpha_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0; end
      xtilde_ready = ($urandom_range(99) >= bp_pct);
      n++;
      if (until_done && xq.size() == 0 && sb.size() == 0) done = 1;
      else if (n >= max_cyc) begin
        if (until_done) chk("stream_timeout", sb.size() + xq.size(), 0);
        done = 1;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  logic        hold_v = 0;
  logic [16:0] hold_d;
  always @(negedge clk) begin
    if (!mon_en) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("stall_stable", {14'd0, xtilde_valid, xtilde_data}, {14'd0, 1'b1, hold_d});
      if (xtilde_valid && xtilde_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {15'd0, xtilde_data}, 32'hFFFF_FFFF);
        end else begin
          logic [16:0] e;
          int fc;
          e  = sb.pop_front();
          fc = fq.pop_front();
          chk("xtilde", {15'd0, xtilde_data}, {15'd0, e});
          if (lat_chk) chk("latency", cyc - fc, 3);
        end
      end
      hold_v = xtilde_valid && !xtilde_ready;
      hold_d = xtilde_data;
    end
  end

  task automatic idle_inputs();
    xhat_valid = 0; alpha_valid = 0; xmean_valid = 0; xhatmean_valid = 0;
    xhat_last_s = 0; xhat_data = 0; alpha_data = 0; xmean_data = 0; xhatmean_data = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    xtilde_ready = 1'b1;
    // Valids high during reset: readies must still stay low.
    xhat_valid = 1; alpha_valid = 1; xmean_valid = 1; xhatmean_valid = 1; xhat_last_s = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, xtilde_valid, xhat_ready, alpha_ready, xmean_ready | xhatmean_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    mon_en = 1;

    // Directed vectors, one sample per block, then framing blocks A (4) and B (1).
    gap_pct = 0; bp_pct = 0; lat_chk = 1; pops = 0; blocks = 0;
    add_par(512, 500, 800);  add_sample(1000, 1);
    add_par(256, 50, 300);   add_sample(100, 1);
    add_par(1023, 65535, 0); add_sample(65535, 1);
    add_par(1, 0, 0);        add_sample(256, 1);
    add_par(700, 12345, 40000);
    add_sample(1000, 0); add_sample(60000, 0); add_sample(0, 0); add_sample(40000, 1);
    add_par(300, 9, 20);     add_sample(65000, 1);
    drive(500, 1);
    chk("param_pops_directed", pops, blocks);

    // Randomized stream with input gaps and output backpressure.
    gap_pct = 30; bp_pct = 40; lat_chk = 0; pops = 0; blocks = 0;
    add_rand_blocks(256);
    drive(5000, 1);
    chk("param_pops_random", pops, blocks);

    // Reset mid-stream.
    gap_pct = 0; bp_pct = 0;
    add_rand_blocks(30);
    drive(8, 0);
    rst = 1'b1;
    mon_en = 0;
    @(negedge clk);
    chk("rst_readies", {28'd0, xhat_ready, alpha_ready, xmean_ready, xhatmean_ready}, 0);
    @(negedge clk);
    chk("rst_valid", {28'd0, xtilde_valid, xhat_ready, alpha_ready, xmean_ready | xhatmean_ready}, 0);
    @(negedge clk);
    chk("rst_hold", {28'd0, xtilde_valid, xhat_ready, alpha_ready, xmean_ready | xhatmean_ready}, 0);
    @(posedge clk); #1;
    xq.delete(); pq.delete(); sb.delete(); fq.delete();
    idle_inputs();
    rst = 1'b0;
    mon_en = 1;

    // Fresh stream after reset must run cleanly.
    gap_pct = 20; bp_pct = 20; pops = 0; blocks = 0;
    add_rand_blocks(20);
    drive(1000, 1);
    chk("param_pops_post_reset", pops, blocks);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_nth_band_predictor
`default_nettype wire

// File: doc/nth_band_predictor.md
Name: nth_band_predictor

Overview:
- Streaming predictor for LCPLC bands after the first, i.e. band index ≥ 1.
- Per sample: xtilde = xmean + alpha·(xhat − xhatmean).
  - xhat is the reconstructed co-located sample of the previous band.
  - alpha, xmean and xhatmean are per-block parameters.
- All ports are AXI-Stream-style valid/ready.
- Sits between the reconstruction/statistics units and the residual (error) computation stage.

Parameters:
- DATA_WIDTH, 16: unsigned sample and mean width.
- ALPHA_WIDTH, 10: unsigned alpha width; fixed point with ALPHA_WIDTH−1 fractional bits (value range [0,2)).

Ports:
- clk, in, 1: single clock, all logic rising-edge.
- rst, in, 1: synchronous, active-high reset.
- xhat_valid, in, 1: xhat beat valid.
- xhat_ready, out, 1: xhat beat accepted.
- xhat_data, in, DATA_WIDTH: unsigned reconstructed sample.
- xhat_last_s, in, 1: marks the last sample of the current block.
- xmean_valid, in, 1: xmean beat valid.
- xmean_ready, out, 1: xmean beat accepted.
- xmean_data, in, DATA_WIDTH: unsigned block mean of the current band.
- xhatmean_valid, in, 1: xhatmean beat valid.
- xhatmean_ready, out, 1: xhatmean beat accepted.
- xhatmean_data, in, DATA_WIDTH: unsigned block mean of xhat.
- alpha_valid, in, 1: alpha beat valid.
- alpha_ready, out, 1: alpha beat accepted.
- alpha_data, in, ALPHA_WIDTH: unsigned alpha.
- xtilde_valid, out, 1: prediction valid.
- xtilde_ready, in, 1: downstream accept.
- xtilde_data, out, DATA_WIDTH+1: signed two's-complement prediction.

Behaviour:
- Reset: rst is synchronous, active-high.
  - xtilde_valid=0 and all *_ready=0 while rst=1.
  - All pipeline valid bits are cleared. A reset mid-stream discards in-flight data; parameters are not held over.
- Input join (stage 0) fires when xhat_valid, alpha_valid, xmean_valid and xhatmean_valid are all 1 and stage 0 can accept (empty, or emptying this cycle).
  - On fire: xhat_ready=1.
  - alpha_ready, xmean_ready and xhatmean_ready equal fire & xhat_last_s. Parameters are peeked for every sample of a block and popped only with the last_s sample.
  - No ready depends combinationally on its own valid alone; readies are a function of all four valids plus pipeline state.
- Arithmetic, full precision:
  - Stage 1: d = signed(xhat) − signed(xhatmean), DATA_WIDTH+1 bits.
  - Stage 2: p = d·alpha, DATA_WIDTH+ALPHA_WIDTH+1 bits signed; then q = p >>> (ALPHA_WIDTH−1), arithmetic shift (floor).
  - Stage 3: s = q + xmean, saturated to the signed DATA_WIDTH+1 range [−2^DATA_WIDTH, 2^DATA_WIDTH−1]. The result is xtilde_data.
- Pipeline: 3 registered stages.
  - Latency is 3 cycles from input fire to xtilde_valid with no backpressure.
  - Throughput is 1 sample/cycle.
  - Each stage advances when its successor is empty or being drained (ready = !valid_next | ready_next).
  - Backpressure on xtilde_ready stalls the whole pipeline without loss or duplication.
  - xtilde_data is stable while xtilde_valid=1 and xtilde_ready=0.
- Order preserved; no reordering, no dropping.
- Any missing input valid stalls the join; the other inputs are not consumed.

Optional Feature:
- Macro: NTHBAND_PREDICTOR_ROUNDING_EN.
- Defined: q = (p + 2^(ALPHA_WIDTH−2)) >>> (ALPHA_WIDTH−1), i.e. round half up.
- Undefined: floor shift as above.
- Latency and handshake are identical in both cases.

Decomposition:
- Package nth_band_predictor_pkg holds:
  - derived width localparams: diff width DATA_WIDTH+1, product width DATA_WIDTH+ALPHA_WIDTH+1, ALPHA_FRAC=ALPHA_WIDTH−1;
  - the saturation bounds.
- One sub-module is natural: axis_join4, a 4-input valid/ready joiner with the last-gated pop of the three parameter streams.

Test Plan:
- alpha=512, xhat=1000, xhatmean=800, xmean=500 → xtilde=700; xtilde_valid rises exactly 3 cycles after the fire.
- alpha=256, xhat=100, xhatmean=300, xmean=50 → xtilde=−50 (0x1FFCE).
- Saturation: alpha=1023, xhat=65535, xhatmean=0, xmean=65535 → xtilde=65535.
- Rounding: alpha=1, xhat=256, xhatmean=0, xmean=0 → 0 without the macro, 1 with NTHBAND_PREDICTOR_ROUNDING_EN.
- Block framing: 4-sample block, last_s only on sample 4; two different parameter sets queued.
  - Samples 1–4 use set A; sample 5 uses set B.
  - alpha/xmean/xhatmean_ready pulse exactly once per block.
- Backpressure and reset:
  - Random xtilde_ready toggling and random input valid gaps over a 256-sample stream → output equals the golden sequence with no loss or duplicate.
  - rst asserted mid-stream → xtilde_valid=0 the next cycle and all readies 0 while rst=1.
